// File: rtl/ow_pkg.sv
// +--------------------------------------------------------------------------+
// | ow_pkg - shared encodings for the 1-Wire command sequencer               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package ow_pkg;

    localparam logic [2:0] CMD_WRITE    = 3'b000;
    localparam logic [2:0] CMD_READ     = 3'b001;
    localparam logic [2:0] CMD_RESET    = 3'b010;
    localparam logic [2:0] CMD_PRESENCE = 3'b011;
    localparam logic [2:0] CMD_SEND_ROM = 3'b100;
    localparam logic [2:0] CMD_IDLE     = 3'b111;

    typedef enum logic [1:0] {
        OP_WRITE_BYTE    = 2'd0,
        OP_READ_BYTE     = 2'd1,
        OP_READ_ROM      = 2'd2,
        OP_PRESENCE_ONLY = 2'd3
    } req_op_e;

    typedef enum logic [1:0] {
        ERR_OK          = 2'd0,
        ERR_NO_PRESENCE = 2'd1,
        ERR_TIMEOUT     = 2'd2,
        ERR_CRC         = 2'd3
    } rsp_err_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RST  = 3'd1,
        S_PRES = 3'd2,
        S_OP   = 3'd3,
        S_RESP = 3'd4
    } state_e;

    // Bit 0 is overloaded: presence in the PRES phase, CRC-ok in the OP phase.
    localparam int ST_CRC_OK    = 0;
    localparam int ST_PRESENT   = 0;
    localparam int ST_DONE_RST  = 1;
    localparam int ST_DONE_ROM  = 1;
    localparam int ST_DONE_BYTE = 2;

    function automatic logic [2:0] op_to_cmd(input req_op_e op);
        case (op)
            OP_WRITE_BYTE: op_to_cmd = CMD_WRITE;
            OP_READ_BYTE:  op_to_cmd = CMD_READ;
            OP_READ_ROM:   op_to_cmd = CMD_SEND_ROM;
            default:       op_to_cmd = CMD_IDLE;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ow_phase_timer.sv
// +--------------------------------------------------------------------------+
// | ow_phase_timer - settle blanking and timeout counting for one phase      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module ow_phase_timer #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SETTLE_CYCLES  = 2,
    parameter int CNT_W          = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic done,
    output logic sample_en,
    output logic timeout
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 2);

    logic [SET_W-1:0] settle_q, settle_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;

    // start is raised in the cycle before phase entry, so the entry cycle
    // sees a freshly loaded settle count and a zero timeout count.
    always_comb begin
        settle_d = settle_q;
        tcnt_d   = tcnt_q;
        if (start) begin
            settle_d = SET_W'(SETTLE_CYCLES);
            tcnt_d   = '0;
        end else begin
            if (settle_q != '0) begin
                settle_d = settle_q - SET_W'(1);
            end
            if (tcnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
                tcnt_d = tcnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_q <= '0;
            tcnt_q   <= '0;
        end else begin
            settle_q <= settle_d;
            tcnt_q   <= tcnt_d;
        end
    end

    assign sample_en = (settle_q == '0);
    // The count hits TIMEOUT_CYCLES on the next edge; a qualified done wins.
    assign timeout   = (tcnt_q >= CNT_W'(TIMEOUT_CYCLES - 1)) && !(sample_en && done);

endmodule

`default_nettype wire

// File: rtl/ow_command_sequencer.sv
// +--------------------------------------------------------------------------+
// | ow_command_sequencer - request -> reset/presence/operation sequencer     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module ow_command_sequencer
    import ow_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SETTLE_CYCLES  = 2,
    parameter int CNT_W          = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [7:0]  req_data,
    output logic [2:0]  cmd,
    output logic [7:0]  data_in,
    input  logic [7:0]  status,
    input  logic [63:0] data_out,
    output logic        rsp_valid,
    output logic [63:0] rsp_data,
    output logic [1:0]  rsp_err,
    output logic        busy
);

    state_e      state_q, state_d;
    req_op_e     op_q, op_d;
    logic [2:0]  cmd_q, cmd_d;
    logic [7:0]  data_in_q, data_in_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [63:0] rsp_data_q, rsp_data_d;
    rsp_err_e    rsp_err_q, rsp_err_d;
    logic        busy_q, busy_d;

    logic        phase_start;
    logic        phase_done;
    logic        sample_en;
    logic        timeout;
    logic        resp_go;
    rsp_err_e    resp_err;
    logic [63:0] resp_data;
    logic        unused_status;

    assign unused_status = ^status[7:3];

    always_comb begin
        phase_done = 1'b0;
        if (state_q == S_RST) begin
            phase_done = status[ST_DONE_RST];
        end else if (state_q == S_OP) begin
            phase_done = (op_q == OP_READ_ROM) ? status[ST_DONE_ROM] : status[ST_DONE_BYTE];
        end
    end

    assign phase_start = (state_d != state_q) &&
                         ((state_d == S_RST) || (state_d == S_PRES) || (state_d == S_OP));

    ow_phase_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SETTLE_CYCLES  (SETTLE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_phase_timer (
        .clk       (clk),
        .rst       (rst),
        .start     (phase_start),
        .done      (phase_done),
        .sample_en (sample_en),
        .timeout   (timeout)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cmd_d       = cmd_q;
        data_in_d   = data_in_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        busy_d      = busy_q;
        resp_go     = 1'b0;
        resp_err    = ERR_OK;
        resp_data   = '0;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_d        = req_op_e'(req_op);
                    data_in_d   = req_data;
                    cmd_d       = CMD_RESET;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = S_RST;
                end
            end
            S_RST: begin
                if (sample_en && phase_done) begin
                    cmd_d   = CMD_PRESENCE;
                    state_d = S_PRES;
                end else if (timeout) begin
                    resp_go  = 1'b1;
                    resp_err = ERR_TIMEOUT;
                end
            end
            S_PRES: begin
                if (sample_en) begin
                    if (!status[ST_PRESENT]) begin
                        resp_go  = 1'b1;
                        resp_err = ERR_NO_PRESENCE;
                    end else if (op_q == OP_PRESENCE_ONLY) begin
                        resp_go = 1'b1;
                    end else begin
                        cmd_d   = op_to_cmd(op_q);
                        state_d = S_OP;
                    end
                end
            end
            S_OP: begin
                if (sample_en && phase_done) begin
                    resp_go = 1'b1;
                    case (op_q)
                        OP_WRITE_BYTE: begin
                            resp_data = {48'b0, data_out[15:0]};
                            resp_err  = status[ST_CRC_OK] ? ERR_OK : ERR_CRC;
                        end
                        OP_READ_BYTE: begin
                            resp_data = {56'b0, data_out[7:0]};
                            resp_err  = status[ST_CRC_OK] ? ERR_OK : ERR_CRC;
                        end
                        OP_READ_ROM: begin
                            resp_data = data_out;
                        end
                        default: begin
                            resp_data = '0;
                        end
                    endcase
                end else if (timeout) begin
                    resp_go  = 1'b1;
                    resp_err = ERR_TIMEOUT;
                end
            end
            S_RESP: begin
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
            default: begin
                cmd_d       = CMD_IDLE;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
        endcase

        if (resp_go) begin
            state_d     = S_RESP;
            cmd_d       = CMD_IDLE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = resp_err;
            rsp_data_d  = (resp_err == ERR_OK) ? resp_data : 64'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_WRITE_BYTE;
            cmd_q       <= CMD_IDLE;
            data_in_q   <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= ERR_OK;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cmd_q       <= cmd_d;
            data_in_q   <= data_in_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd       = cmd_q;
    assign data_in   = data_in_q;
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire
